// File: rtl/host_rx_frame_assembler.sv
// Host RX frame assembler: collects a length-prefixed byte frame into a 1024-bit packet word and hands it downstream.
// Optional inter-byte timeout in COLLECT is enabled with the HOST_RX_TIMEOUT_EN macro.
module host_rx_frame_assembler #(
    parameter int MAX_BYTES      = 128,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_byte,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [1023:0] input_data,
    output logic          send_packet,
    input  logic          dp_done,
    input  logic          dp_error,
    output logic          result_valid,
    output logic          result_error,
    output logic          frame_error,
    output logic [1:0]    err_code
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE,
        S_WAIT_DONE
    } state_t;

    localparam logic [7:0] MAX_LEN = 8'(MAX_BYTES);

    state_t          state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      count_q, count_d;
    logic [1023:0]   data_q, data_d;
    logic            result_valid_q, result_valid_d;
    logic            result_error_q, result_error_d;
    logic            frame_error_q, frame_error_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            accept;
    logic            timeout;

    // Ready is forced low while reset is held so no byte is consumed by a frame about to be dropped.
    assign rx_ready = !reset && (state_q == S_IDLE || state_q == S_COLLECT);
    assign accept   = rx_valid && rx_ready;

`ifdef HOST_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_q, idle_d;

    always_comb begin
        idle_d  = '0;
        timeout = 1'b0;
        if (state_q == S_COLLECT && !accept) begin
            if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        count_d        = count_q;
        data_d         = data_q;
        result_valid_d = 1'b0;
        result_error_d = result_error_q;
        frame_error_d  = 1'b0;
        err_code_d     = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (rx_byte == 8'd0 || rx_byte > MAX_LEN) begin
                        frame_error_d = 1'b1;
                        err_code_d    = 2'b01;
                    end else begin
                        data_d  = '0;
                        len_d   = rx_byte;
                        count_d = 8'd0;
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                // A byte arriving in the same cycle as the timeout wins.
                if (accept) begin
                    data_d[{count_q[6:0], 3'b000} +: 8] = rx_byte;
                    count_d = count_q + 8'd1;
                    if (count_q + 8'd1 == len_q) begin
                        state_d = S_ISSUE;
                    end
                end else if (timeout) begin
                    frame_error_d = 1'b1;
                    err_code_d    = 2'b10;
                    data_d        = '0;
                    state_d       = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (dp_done) begin
                    result_valid_d = 1'b1;
                    result_error_d = dp_error;
                    state_d        = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            len_q          <= 8'd0;
            count_q        <= 8'd0;
            data_q         <= '0;
            result_valid_q <= 1'b0;
            result_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
            err_code_q     <= 2'b00;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            count_q        <= count_d;
            data_q         <= data_d;
            result_valid_q <= result_valid_d;
            result_error_q <= result_error_d;
            frame_error_q  <= frame_error_d;
            err_code_q     <= err_code_d;
        end
    end

    assign input_data   = data_q;
    assign send_packet  = (state_q == S_ISSUE);
    assign result_valid = result_valid_q;
    assign result_error = result_error_q;
    assign frame_error  = frame_error_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_host_rx_frame_assembler.sv
// Directed bench for host_rx_frame_assembler: byte-array frame model checked every cycle plus literal packet checks.
module tb_host_rx_frame_assembler;

    localparam int TO   = 20;
    localparam int MAXB = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_ready;
    logic [1023:0] input_data;
    logic          send_packet;
    logic          dp_done;
    logic          dp_error;
    logic          result_valid;
    logic          result_error;
    logic          frame_error;
    logic [1:0]    err_code;

    always #5 clk = ~clk;

    host_rx_frame_assembler #(.MAX_BYTES(MAXB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .input_data(input_data), .send_packet(send_packet), .dp_done(dp_done), .dp_error(dp_error),
        .result_valid(result_valid), .result_error(result_error),
        .frame_error(frame_error), .err_code(err_code)
    );

    int checks = 0;
    int failures = 0;
    int send_cnt = 0;
    int fe_cnt = 0;
    int rv_cnt = 0;

    // Model: frame bytes in an array, how many payload bytes are still owed, and packet hand-off flags.
    bit         m_valid = 1'b0;
    int         m_remaining = -1;
    int         m_got = 0;
    int         m_idle = 0;
    logic [7:0] m_pkt [128];
    bit         m_issue = 1'b0;
    bit         m_wait = 1'b0;
    bit         m_rv = 1'b0;
    bit         m_re = 1'b0;
    bit         m_fe = 1'b0;
    logic [1:0] m_ec = 2'b00;

    function automatic logic [1023:0] m_data();
        logic [1023:0] v;
        for (int i = 0; i < 128; i++) v[i*8 +: 8] = m_pkt[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        int idx;
        checks++;
        if (act !== exp) begin
            failures++;
            idx = 0;
            for (int i = 127; i >= 0; i--) if (act[i*8 +: 8] !== exp[i*8 +: 8]) idx = i;
            $display("FAIL %s byte%0d actual=%h required=%h t=%0t", name, idx,
                     act[idx*8 +: 8], exp[idx*8 +: 8], $time);
        end
    endtask

    always @(posedge clk) begin
        bit acc;
        acc = rx_valid && !reset && !m_issue && !m_wait;
        if (reset) begin
            m_valid = 1'b1;
            m_remaining = -1;
            m_got = 0;
            m_idle = 0;
            for (int i = 0; i < 128; i++) m_pkt[i] = 8'h00;
            m_issue = 1'b0;
            m_wait = 1'b0;
            m_rv = 1'b0;
            m_re = 1'b0;
            m_fe = 1'b0;
            m_ec = 2'b00;
        end else if (m_valid) begin
            m_fe = 1'b0;
            m_rv = 1'b0;
            if (m_issue) begin
                m_issue = 1'b0;
                m_wait = 1'b1;
            end else if (m_wait) begin
                if (dp_done) begin
                    m_wait = 1'b0;
                    m_rv = 1'b1;
                    m_re = dp_error;
                end
            end else if (acc) begin
                m_idle = 0;
                if (m_remaining < 0) begin
                    if (rx_byte == 8'd0 || int'(rx_byte) > MAXB) begin
                        m_fe = 1'b1;
                        m_ec = 2'b01;
                    end else begin
                        for (int i = 0; i < 128; i++) m_pkt[i] = 8'h00;
                        m_got = 0;
                        m_remaining = int'(rx_byte);
                    end
                end else begin
                    m_pkt[m_got] = rx_byte;
                    m_got++;
                    m_remaining--;
                    if (m_remaining == 0) begin
                        m_remaining = -1;
                        m_issue = 1'b1;
                    end
                end
            end
`ifdef HOST_RX_TIMEOUT_EN
            else if (m_remaining > 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_fe = 1'b1;
                    m_ec = 2'b10;
                    for (int i = 0; i < 128; i++) m_pkt[i] = 8'h00;
                    m_remaining = -1;
                    m_idle = 0;
                end
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (send_packet === 1'b1) send_cnt++;
        if (frame_error === 1'b1) fe_cnt++;
        if (result_valid === 1'b1) rv_cnt++;
        if (m_valid) begin
            chk("rx_ready", rx_ready, !reset && !m_issue && !m_wait);
            chk("send_packet", send_packet, m_issue);
            chk("result_valid", result_valid, m_rv);
            chk("frame_error", frame_error, m_fe);
            chk("err_code", err_code, m_ec);
            chk_vec("input_data", input_data, m_data());
            if (m_rv) chk("result_error", result_error, m_re);
        end
    end

    logic [7:0] q[$];

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        rx_valid = 1'b1;
        rx_byte = b;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = (rx_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        rx_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL byte_accept actual=not_accepted required=accepted byte=%h", b);
        end
    endtask

    task automatic send_q();
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_send(input string name, input logic [1023:0] exp);
        bit seen;
        int n;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (send_packet === 1'b1) seen = 1'b1;
        end
        chk({name, "_send_seen"}, seen, 1);
        chk({name, "_send_latency"}, n, 1);
        if (seen) chk_vec({name, "_packet"}, input_data, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic finish_done(input string name, input bit err, input int delay);
        idle(delay);
        dp_done = 1'b1;
        dp_error = err;
        @(posedge clk);
        #1;
        dp_done = 1'b0;
        dp_error = 1'b0;
        @(negedge clk);
        chk({name, "_result_valid"}, result_valid, 1);
        chk({name, "_result_error"}, result_error, err);
        chk({name, "_ready_after_done"}, rx_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, f0, r0;
        logic [1023:0] v;
        bit seen;
        reset = 1'b1;
        rx_byte = 8'h00;
        rx_valid = 1'b0;
        dp_done = 1'b0;
        dp_error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", rx_ready, 1);
        chk_vec("reset_data", input_data, '0);
        chk("reset_err_code", err_code, 0);
        @(posedge clk);
        #1;

        // Encrypt enable
        q = {8'h09, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01};
        send_q();
        v = '0;
        v[71:0] = 72'h0101FFFFFFFFFFFF01;
        wait_send("encrypt", v);
        idle(3);
        chk("encrypt_wait_ready", rx_ready, 0);
        finish_done("encrypt", 1'b0, 0);

        // Read yaw then invalid command back to back
        q = {8'h07, 8'h03, 8'h27, 8'hFF, 8'h27, 8'hFF, 8'h27, 8'hFF};
        send_q();
        v = '0;
        v[55:0] = 56'hFF27FF27FF2703;
        wait_send("yaw", v);
        finish_done("yaw", 1'b0, 0);
        q = {8'h07, 8'h05, 8'h27, 8'hFF, 8'h27, 8'hFF, 8'h27, 8'hFF};
        send_q();
        v[55:0] = 56'hFF27FF27FF2705;
        wait_send("badcmd", v);
        finish_done("badcmd", 1'b1, 2);

        // dp_done while idle is ignored
        r0 = rv_cnt;
        dp_done = 1'b1;
        dp_error = 1'b1;
        idle(1);
        dp_done = 1'b0;
        dp_error = 1'b0;
        idle(2);
        chk("idle_done_ignored", rv_cnt - r0, 0);

        // Bad lengths
        s0 = send_cnt;
        f0 = fe_cnt;
        send_byte(8'h00);
        send_byte(8'h81);
        idle(2);
        chk("badlen_fe_pulses", fe_cnt - f0, 2);
        chk("badlen_no_send", send_cnt - s0, 0);
        chk("badlen_err_code", err_code, 2'b01);
        q = {8'h03, 8'h11, 8'h22, 8'h33};
        send_q();
        v = '0;
        v[23:0] = 24'h332211;
        wait_send("after_badlen", v);
        finish_done("after_badlen", 1'b0, 1);

        // Maximum length
        s0 = send_cnt;
        q = {8'h80};
        for (int i = 0; i < 128; i++) q.push_back(8'(i));
        send_q();
        @(negedge clk);
        chk("max_top_byte", input_data[1023:1016], 8'h7F);
        chk("max_low_byte", input_data[7:0], 8'h00);
        chk("max_send", send_packet, 1);
        @(posedge clk);
        #1;
        idle(2);
        chk("max_single_send", send_cnt - s0, 1);
        finish_done("max", 1'b0, 0);

        // Inter-byte stall
        send_byte(8'h04);
        send_byte(8'hAA);
`ifdef HOST_RX_TIMEOUT_EN
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            if (frame_error === 1'b1) begin
                seen = 1'b1;
                chk("timeout_err_code", err_code, 2'b10);
                chk_vec("timeout_data", input_data, '0);
                chk("timeout_ready", rx_ready, 1);
            end
        end
        chk("timeout_seen", seen, 1);
        @(posedge clk);
        #1;
`else
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (frame_error === 1'b1) seen = 1'b1;
        end
        chk("no_timeout", seen, 0);
        @(posedge clk);
        #1;
        q = {8'hBB, 8'hCC, 8'hDD};
        send_q();
        v = '0;
        v[31:0] = 32'hDDCCBBAA;
        wait_send("stall", v);
        finish_done("stall", 1'b0, 0);
`endif

        // Reset mid-COLLECT
        s0 = send_cnt;
        q = {8'h09, 8'hA1, 8'hA2, 8'hA3};
        send_q();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        @(negedge clk);
        chk_vec("rst_collect_data", input_data, '0);
        chk("rst_collect_ready", rx_ready, 1);
        chk("rst_collect_err_code", err_code, 0);
        chk("rst_collect_send", send_packet, 0);
        @(posedge clk);
        #1;
        idle(2);
        chk("rst_collect_no_send", send_cnt - s0, 0);
        q = {8'h09, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        send_q();
        v = '0;
        v[71:0] = 72'h090807060504030201;
        wait_send("fresh", v);
        finish_done("fresh", 1'b0, 1);

        // Reset mid-WAIT_DONE, late dp_done ignored
        q = {8'h01, 8'h5A};
        send_q();
        v = '0;
        v[7:0] = 8'h5A;
        wait_send("rst_wait", v);
        r0 = rv_cnt;
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        dp_done = 1'b1;
        idle(1);
        dp_done = 1'b0;
        idle(3);
        chk("rst_wait_no_result", rv_cnt - r0, 0);
        chk("rst_wait_ready", rx_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
